// File: rtl/led_anim_pkg.sv
// -----------------------------------------------------------------------------
// led_anim_pkg
// Shared definitions for the LED animation path: the width of the mode bus,
// the symbolic mode encodings used by the animation top level, and the step
// request type used by the mode selector.
// -----------------------------------------------------------------------------
package led_anim_pkg;

    localparam int MODE_W = 2;

    // Mode encodings shared with the animation top level.
    localparam logic [MODE_W-1:0] MODE_SHIFT = 2'd0;
    localparam logic [MODE_W-1:0] MODE_FILL  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'd2;
    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd3;

    // Kind of mode update requested in a given cycle.
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_NEXT = 2'd1,
        STEP_PREV = 2'd2
    } step_e;

endpackage : led_anim_pkg

// File: rtl/mode_select_if.sv
// -----------------------------------------------------------------------------
// mode_select_if
// Bundles the user-facing controls and the mode result of mode_select.
//   btn_next  raw, asynchronous "next mode" push-button (active high)
//   btn_prev  raw, asynchronous "previous mode" push-button (active high)
//   auto_en   level, enables periodic automatic mode stepping
//   mode      current mode (registered in mode_select)
//   mode_chg  one-cycle strobe following every mode update
// Modports:
//   master  drives the buttons / auto_en and observes mode (board / bench)
//   slave   mode_select side
// -----------------------------------------------------------------------------
interface mode_select_if;
    import led_anim_pkg::*;

    logic              btn_next;
    logic              btn_prev;
    logic              auto_en;
    logic [MODE_W-1:0] mode;
    logic              mode_chg;

    modport master (
        output btn_next,
        output btn_prev,
        output auto_en,
        input  mode,
        input  mode_chg
    );

    modport slave (
        input  btn_next,
        input  btn_prev,
        input  auto_en,
        output mode,
        output mode_chg
    );

endinterface : mode_select_if

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stability counter for one push-button.
// A new level is accepted only after it has been seen on the synchronised
// input for DB_CYCLES consecutive cycles; shorter glitches are discarded.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   btn_raw  raw asynchronous button input
//   btn_db   debounced button level
//   press    high for one cycle after btn_db rises (releases ignored)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int              DB_W      = 16,
    parameter logic [DB_W-1:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_CYCLES - DB_W'(1);

    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;
    logic            db_d;
    logic            db_prev_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Stability counter: clears whenever the input agrees with the accepted
    // level; a disagreement that persists to CNT_LAST flips the level.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    // Synchroniser, accepted level, its one-cycle delay and the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign btn_db = db_q;
    // Rising edge of the accepted level, derived purely from flops.
    assign press  = db_q & ~db_prev_q;

endmodule : btn_debounce

// File: rtl/mode_select.sv
// -----------------------------------------------------------------------------
// mode_select
// Produces the 2-bit animation mode from two debounced push-buttons and an
// optional auto-cycle timer. The mode wraps over 0..NUM_MODES-1; every update
// is followed by a one-cycle mode_chg strobe so downstream can restart.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mode_select_if.slave: btn_next, btn_prev, auto_en in;
//          mode, mode_chg out (both registered)
// Step priority per cycle: both presses (cancel, no step) > next > prev >
// auto tick. Any press restarts the auto timer, so a press landing on a tick
// yields a single step.
// -----------------------------------------------------------------------------
module mode_select
    import led_anim_pkg::*;
#(
    parameter int                DB_W        = 16,
    parameter logic [DB_W-1:0]   DB_CYCLES   = 16'd50000,
    parameter int                AUTO_W      = 26,
    parameter logic [AUTO_W-1:0] AUTO_CYCLES = 26'd50000000,
    parameter int                NUM_MODES   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mode_select_if.slave  bus
);

    localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST  = AUTO_CYCLES - AUTO_W'(1);

    // Forward step with wrap; any out-of-range value recovers to 0.
    function automatic logic [MODE_W-1:0] step_up(input logic [MODE_W-1:0] m);
        logic [MODE_W-1:0] r;
        if (int'(m) >= NUM_MODES - 1) begin
            r = '0;
        end else begin
            r = m + 2'd1;
        end
        return r;
    endfunction

    // Backward step with wrap; any out-of-range value recovers to 0.
    function automatic logic [MODE_W-1:0] step_down(input logic [MODE_W-1:0] m);
        logic [MODE_W-1:0] r;
        if (int'(m) >= NUM_MODES) begin
            r = '0;
        end else if (m == '0) begin
            r = MODE_LAST;
        end else begin
            r = m - 2'd1;
        end
        return r;
    endfunction

    logic              nxt_db_s;
    logic              prv_db_s;
    logic              nxt_press_s;
    logic              prv_press_s;
    logic              db_unused_s;
    step_e             step_s;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;
    logic              chg_q;
    logic              chg_d;
    logic [AUTO_W-1:0] timer_q;
    logic [AUTO_W-1:0] timer_d;

    btn_debounce #(
        .DB_W      (DB_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_next),
        .btn_db  (nxt_db_s),
        .press   (nxt_press_s)
    );

    btn_debounce #(
        .DB_W      (DB_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_db_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_prev),
        .btn_db  (prv_db_s),
        .press   (prv_press_s)
    );

    // Only the press strobes matter here; the debounced levels are not used.
    assign db_unused_s = nxt_db_s ^ prv_db_s;

    // Step arbitration and auto timer next state.
    always_comb begin
        step_s  = STEP_NONE;
        timer_d = timer_q;
        if (nxt_press_s && prv_press_s) begin
            step_s  = STEP_NONE;
            timer_d = '0;
        end else if (nxt_press_s) begin
            step_s  = STEP_NEXT;
            timer_d = '0;
        end else if (prv_press_s) begin
            step_s  = STEP_PREV;
            timer_d = '0;
        end else if (!bus.auto_en) begin
            timer_d = '0;
        end else if (timer_q >= AUTO_LAST) begin
            step_s  = STEP_NEXT;
            timer_d = '0;
        end else begin
            timer_d = timer_q + AUTO_W'(1);
        end
    end

    // Mode and strobe next state from the arbitrated step.
    always_comb begin
        case (step_s)
            STEP_NEXT: begin
                mode_d = step_up(mode_q);
                chg_d  = 1'b1;
            end
            STEP_PREV: begin
                mode_d = step_down(mode_q);
                chg_d  = 1'b1;
            end
            default: begin
                mode_d = mode_q;
                chg_d  = 1'b0;
            end
        endcase
    end

    // Mode, change strobe and auto timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_SHIFT;
            chg_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            mode_q  <= mode_d;
            chg_q   <= chg_d;
            timer_q <= timer_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.mode_chg = chg_q;

endmodule : mode_select
